// File: rtl/ultrasonic_pkg.sv
// Shared FSM state type, 100 MHz default timing constants and a
// parameter-legality helper for the ultrasonic trigger block.
package ultrasonic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    ECHO,
    HOLD
  } state_t;

  localparam int unsigned TRIG_CYC_DEF    = 1000;     // 10 us
  localparam int unsigned TIMEOUT_CYC_DEF = 3800000;  // 38 ms
  localparam int unsigned PERIOD_CYC_DEF  = 6000000;  // 60 ms

  function automatic bit params_ok(input int unsigned trig_cyc,
                                   input int unsigned timeout_cyc,
                                   input int unsigned period_cyc);
    return (trig_cyc >= 1) && (trig_cyc < timeout_cyc) && (timeout_cyc < period_cyc);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the asynchronous echo input, with one-cycle
// rise and fall pulses derived from the synchronized level and its delayed copy.
module echo_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_echo,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_dly  <= 1'b0;
    end else begin
      r_meta <= i_echo;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_dly;
  assign o_fall = ~r_sync & r_dly;

endmodule

// File: rtl/ultrasonic_trigger.sv
// Ultrasonic range-sensor sequencer: periodic trigger pulse, echo gating and
// done/timeout strobes. Define TRIG_TIMEOUT_EN to enable the echo timeout abort.
module ultrasonic_trigger
  import ultrasonic_pkg::*;
#(
  parameter int unsigned TRIG_CYC    = TRIG_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned PERIOD_CYC  = PERIOD_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic echo,
  output logic trig,
  output logic echo_ena,
  output logic meas_done,
  output logic timeout,
  output logic busy
);

  if (!params_ok(TRIG_CYC, TIMEOUT_CYC, PERIOD_CYC)) begin : g_param_err
    $fatal(1, "ultrasonic_trigger: need 1 <= TRIG_CYC < TIMEOUT_CYC < PERIOD_CYC");
  end

  localparam int PW = $clog2(PERIOD_CYC);
  localparam logic [PW-1:0] P_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [PW-1:0] T_LAST = PW'(TRIG_CYC - 1);
`ifdef TRIG_TIMEOUT_EN
  localparam logic [PW-1:0] TO_LAST = PW'(TIMEOUT_CYC - 1);
`endif

  logic          w_rise;
  logic          w_fall;
  state_t        r_state;
  logic [PW-1:0] r_pcnt;
  logic          r_trig;
  logic          r_ena;
  logic          r_done;
  logic          r_busy;
`ifdef TRIG_TIMEOUT_EN
  logic          r_tmo;
`endif

  echo_sync u_echo_sync (
    .i_clk   (clk),
    .i_reset (reset),
    .i_echo  (echo),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // pcnt doubles as the trigger-width counter: it is cleared on every TRIG entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pcnt  <= '0;
      r_trig  <= 1'b0;
      r_ena   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
`ifdef TRIG_TIMEOUT_EN
      r_tmo  <= 1'b0;
`endif
      if ((r_state != IDLE) && (r_pcnt != P_LAST)) begin
        r_pcnt <= r_pcnt + PW'(1);
      end

      case (r_state)
        IDLE: begin
          if (run) begin
            r_state <= TRIG;
            r_pcnt  <= '0;
            r_trig  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        TRIG: begin
          if (r_pcnt == T_LAST) begin
            r_state <= WAIT_RISE;
            r_trig  <= 1'b0;
          end
        end
        WAIT_RISE: begin
`ifdef TRIG_TIMEOUT_EN
          if (r_pcnt == TO_LAST) begin
            r_state <= HOLD;
            r_tmo   <= 1'b1;
          end else
`endif
          if (w_rise) begin
            r_state <= ECHO;
            r_ena   <= 1'b1;
          end
        end
        ECHO: begin
`ifdef TRIG_TIMEOUT_EN
          if (r_pcnt == TO_LAST) begin
            r_state <= HOLD;
            r_ena   <= 1'b0;
            r_tmo   <= 1'b1;
          end else
`endif
          if (w_fall) begin
            r_state <= HOLD;
            r_ena   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        HOLD: begin
          if (r_pcnt == P_LAST) begin
            if (run) begin
              r_state <= TRIG;
              r_pcnt  <= '0;
              r_trig  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_trig  <= 1'b0;
          r_ena   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign trig      = r_trig;
  assign echo_ena  = r_ena;
  assign meas_done = r_done;
  assign busy      = r_busy;
`ifdef TRIG_TIMEOUT_EN
  assign timeout   = r_tmo;
`else
  assign timeout   = 1'b0;
`endif

endmodule
